// File: rtl/enemy_missile_dispatcher_pkg.sv
// Shared types, default parameters and helpers for the enemy missile dispatcher.
package enemy_missile_dispatcher_pkg;

    localparam int unsigned DEF_Y_MAX          = 479;
    localparam int unsigned DEF_STEP           = 1;
    localparam int unsigned DEF_SPAWN_INTERVAL = 60;
    localparam int unsigned DEF_WAVE_SIZE      = 10;

    localparam int unsigned Y_W     = 9;
    localparam int unsigned Y_INT_W = 10;
    localparam int unsigned TGT_W   = 2;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAIN  = 2'd2
    } wave_state_e;

    // Only three targets exist; any higher index aims at the rightmost one.
    function automatic logic [TGT_W-1:0] sat_target(input logic [SEL_W-1:0] sel);
        logic [TGT_W-1:0] res;
        if (sel > SEL_W'(2)) begin
            res = TGT_W'(2);
        end else begin
            res = sel[TGT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/enemy_missile_slot.sv
// One enemy missile slot: holds occupancy, row and target; advances, impacts or dies on kill.
module enemy_missile_slot
    import enemy_missile_dispatcher_pkg::*;
#(
    parameter int unsigned Y_MAX = DEF_Y_MAX,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             launch,
    input  logic [TGT_W-1:0] launch_tgt,
    input  logic             kill,
    output logic             active,
    output logic [Y_W-1:0]   y,
    output logic [TGT_W-1:0] tgt,
    output logic             impact
);

    logic               active_q, active_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [TGT_W-1:0]   tgt_q, tgt_d;
    logic               impact_q, impact_d;
    logic [Y_INT_W-1:0] y_next;

    // Kill wins over movement; a slot only accepts a launch while free.
    always_comb begin
        active_d = active_q;
        y_d      = y_q;
        tgt_d    = tgt_q;
        impact_d = 1'b0;
        y_next   = {1'b0, y_q} + Y_INT_W'(STEP);

        if (active_q) begin
            if (kill) begin
                active_d = 1'b0;
                y_d      = '0;
            end else if (frame_tick) begin
                if (y_next >= Y_INT_W'(Y_MAX)) begin
                    active_d = 1'b0;
                    y_d      = '0;
                    impact_d = 1'b1;
                end else begin
                    y_d = y_next[Y_W-1:0];
                end
            end
        end else if (launch) begin
            active_d = 1'b1;
            y_d      = '0;
            tgt_d    = launch_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            y_q      <= '0;
            tgt_q    <= '0;
            impact_q <= 1'b0;
        end else begin
            active_q <= active_d;
            y_q      <= y_d;
            tgt_q    <= tgt_d;
            impact_q <= impact_d;
        end
    end

    assign active = active_q;
    assign y      = y_q;
    assign tgt    = tgt_q;
    assign impact = impact_q;

endmodule

// File: rtl/enemy_missile_dispatcher.sv
// Wave sequencer and slot allocator for enemy missiles; each slot lives in enemy_missile_slot.
module enemy_missile_dispatcher
    import enemy_missile_dispatcher_pkg::*;
#(
    parameter int unsigned N_SLOTS        = 4,
    parameter int unsigned Y_MAX          = DEF_Y_MAX,
    parameter int unsigned STEP           = DEF_STEP,
    parameter int unsigned SPAWN_INTERVAL = DEF_SPAWN_INTERVAL,
    parameter int unsigned WAVE_SIZE      = DEF_WAVE_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           target_sel,
    input  logic                       frame_tick,
    input  logic                       wave_start,
    input  logic [N_SLOTS-1:0]         kill,
    output logic [N_SLOTS-1:0]         missile_active,
    output logic [Y_W*N_SLOTS-1:0]     missile_y,
    output logic [TGT_W*N_SLOTS-1:0]   missile_tgt,
    output logic [N_SLOTS-1:0]         impact,
    output logic                       wave_busy,
    output logic                       wave_done
);

    localparam int unsigned CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int unsigned BUD_W = (WAVE_SIZE > 0) ? $clog2(WAVE_SIZE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SPAWN_INTERVAL - 1);

    wave_state_e        state_q, state_d;
    logic [BUD_W-1:0]   budget_q, budget_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wave_busy_q, wave_busy_d;
    logic               wave_done_q, wave_done_d;

    logic [N_SLOTS-1:0] free_slots;
    logic [N_SLOTS-1:0] alloc_oh;
    logic               alloc_found;
    logic               launch_c;
    logic [TGT_W-1:0]   tgt_sat;

    assign tgt_sat = sat_target(target_sel);

    // Lowest-index free slot, judged on occupancy at the start of the cycle.
    always_comb begin
        free_slots  = ~missile_active;
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (free_slots[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        budget_d    = budget_q;
        cnt_d       = cnt_q;
        launch_c    = 1'b0;
        wave_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (wave_start) begin
                    state_d  = LAUNCH;
                    budget_d = BUD_W'(WAVE_SIZE);
                    cnt_d    = '0;
                end
            end
            LAUNCH: begin
                // Counter parks at terminal count until a slot frees up.
                if (frame_tick) begin
                    if (cnt_q == CNT_TERM) begin
                        if ((budget_q != '0) && alloc_found) begin
                            launch_c = 1'b1;
                            cnt_d    = '0;
                            budget_d = budget_q - BUD_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (budget_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (missile_active == '0) begin
                    state_d     = IDLE;
                    wave_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wave_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            budget_q    <= '0;
            cnt_q       <= '0;
            wave_busy_q <= 1'b0;
            wave_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            budget_q    <= budget_d;
            cnt_q       <= cnt_d;
            wave_busy_q <= wave_busy_d;
            wave_done_q <= wave_done_d;
        end
    end

    assign wave_busy = wave_busy_q;
    assign wave_done = wave_done_q;

    for (genvar i = 0; i < int'(N_SLOTS); i++) begin : g_slot
        enemy_missile_slot #(
            .Y_MAX (Y_MAX),
            .STEP  (STEP)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_tick (frame_tick),
            .launch     (launch_c & alloc_oh[i]),
            .launch_tgt (tgt_sat),
            .kill       (kill[i]),
            .active     (missile_active[i]),
            .y          (missile_y[Y_W*i +: Y_W]),
            .tgt        (missile_tgt[TGT_W*i +: TGT_W]),
            .impact     (impact[i])
        );
    end

endmodule

// File: tb/tb_enemy_missile_dispatcher.sv
// Directed bench for enemy_missile_dispatcher at default parameters.
module tb_enemy_missile_dispatcher;
    import enemy_missile_dispatcher_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  target_sel;
    logic        frame_tick;
    logic        wave_start;
    logic [3:0]  kill;
    logic [3:0]  missile_active;
    logic [35:0] missile_y;
    logic [7:0]  missile_tgt;
    logic [3:0]  impact;
    logic        wave_busy;
    logic        wave_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    enemy_missile_dispatcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .target_sel     (target_sel),
        .frame_tick     (frame_tick),
        .wave_start     (wave_start),
        .kill           (kill),
        .missile_active (missile_active),
        .missile_y      (missile_y),
        .missile_tgt    (missile_tgt),
        .impact         (impact),
        .wave_busy      (wave_busy),
        .wave_done      (wave_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns at the following falling edge.
    task automatic step(input logic ft, input logic ws, input logic [3:0] k);
        frame_tick = ft;
        wave_start = ws;
        kill       = k;
        @(negedge clk);
        frame_tick = 1'b0;
        wave_start = 1'b0;
        kill       = 4'b0000;
        if (wave_done) done_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) step(1'b1, 1'b0, 4'b0000);
    endtask

    function automatic logic [8:0] y_of(input int i);
        return missile_y[9*i +: 9];
    endfunction

    function automatic logic [1:0] tgt_of(input int i);
        return missile_tgt[2*i +: 2];
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_active"}, 64'(missile_active), 64'h0);
        check_eq({tag, "_y"},      64'(missile_y),      64'h0);
        check_eq({tag, "_tgt"},    64'(missile_tgt),    64'h0);
        check_eq({tag, "_impact"}, 64'(impact),         64'h0);
        check_eq({tag, "_busy"},   64'(wave_busy),      64'h0);
        check_eq({tag, "_done"},   64'(wave_done),      64'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        target_sel = 3'd0;
        frame_tick = 1'b0;
        wave_start = 1'b0;
        kill       = 4'b0000;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_state",  64'(dut.state_q),  64'(IDLE));
        check_eq("reset_budget", 64'(dut.budget_q), 64'd0);
        check_eq("reset_cnt",    64'(dut.cnt_q),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Wave 1: first launch, slot saturation, kill-freed relaunch, impact, kill vs impact.
        target_sel = 3'd1;
        step(1'b0, 1'b1, 4'b0000);
        check_eq("w1_busy", 64'(wave_busy), 64'd1);
        ticks(59);
        check_eq("w1_t59_active", 64'(missile_active), 64'h0);
        check_eq("w1_t59_cnt",    64'(dut.cnt_q),      64'd59);
        ticks(1);
        check_eq("w1_t60_active", 64'(missile_active), 64'b0001);
        check_eq("w1_t60_y0",     64'(y_of(0)),        64'd0);
        check_eq("w1_t60_tgt0",   64'(tgt_of(0)),      64'd1);
        check_eq("w1_t60_budget", 64'(dut.budget_q),   64'd9);
        check_eq("w1_t60_cnt",    64'(dut.cnt_q),      64'd0);

        target_sel = 3'd0;
        ticks(240);
        check_eq("w1_t300_active", 64'(missile_active), 64'b1111);
        check_eq("w1_t300_cnt",    64'(dut.cnt_q),      64'd59);
        check_eq("w1_t300_budget", 64'(dut.budget_q),   64'd6);
        check_eq("w1_t300_y0",     64'(y_of(0)),        64'd240);

        step(1'b0, 1'b0, 4'b0100);
        check_eq("w1_kill2_active", 64'(missile_active), 64'b1011);
        check_eq("w1_kill2_impact", 64'(impact),         64'h0);
        check_eq("w1_kill2_y2",     64'(y_of(2)),        64'd0);

        target_sel = 3'd5;
        ticks(1);
        check_eq("w1_t301_active", 64'(missile_active), 64'b1111);
        check_eq("w1_t301_tgt2",   64'(tgt_of(2)),      64'd2);
        check_eq("w1_t301_y2",     64'(y_of(2)),        64'd0);
        check_eq("w1_t301_y0",     64'(y_of(0)),        64'd241);
        check_eq("w1_t301_y1",     64'(y_of(1)),        64'd181);
        check_eq("w1_t301_y3",     64'(y_of(3)),        64'd61);
        check_eq("w1_t301_budget", 64'(dut.budget_q),   64'd5);

        step(1'b0, 1'b1, 4'b0000);
        check_eq("w1_ws_ignored_budget", 64'(dut.budget_q), 64'd5);
        check_eq("w1_ws_ignored_state",  64'(dut.state_q),  64'(LAUNCH));

        ticks(237);
        check_eq("w1_t538_y0",     64'(y_of(0)),        64'd478);
        check_eq("w1_t538_active", 64'(missile_active), 64'b1111);
        ticks(1);
        check_eq("w1_t539_active", 64'(missile_active), 64'b1110);
        check_eq("w1_t539_impact", 64'(impact),         64'b0001);
        check_eq("w1_t539_tgt0",   64'(tgt_of(0)),      64'd1);
        check_eq("w1_t539_y0",     64'(y_of(0)),        64'd0);
        step(1'b0, 1'b0, 4'b0000);
        check_eq("w1_post_impact", 64'(impact), 64'h0);

        ticks(59);
        check_eq("w1_t598_y1",     64'(y_of(1)),        64'd478);
        check_eq("w1_t598_tgt0",   64'(tgt_of(0)),      64'd2);
        step(1'b1, 1'b0, 4'b0010);
        check_eq("w1_killimp_active", 64'(missile_active), 64'b1101);
        check_eq("w1_killimp_impact", 64'(impact),         64'h0);
        step(1'b0, 1'b0, 4'b0000);
        check_eq("w1_killimp_impact2", 64'(impact), 64'h0);

        // Asynchronous reset in the middle of the wave.
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check_eq("midrst_hold_impact", 64'(impact), 64'h0);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'b0000);
        check_all_zero("midrst_rel");

        // Wave 2: full wave, no kills, target_sel=3 saturates to 2.
        done_cnt   = 0;
        target_sel = 3'd3;
        step(1'b0, 1'b1, 4'b0000);
        ticks(1079);
        check_eq("w2_t1079_state",  64'(dut.state_q),    64'(LAUNCH));
        check_eq("w2_t1079_budget", 64'(dut.budget_q),   64'd1);
        check_eq("w2_t1079_active", 64'(missile_active), 64'b1101);
        check_eq("w2_t1079_impact", 64'(impact),         64'b0010);
        ticks(1);
        check_eq("w2_t1080_state",  64'(dut.state_q),    64'(DRAIN));
        check_eq("w2_t1080_budget", 64'(dut.budget_q),   64'd0);
        check_eq("w2_t1080_active", 64'(missile_active), 64'b1111);
        check_eq("w2_t1080_tgt1",   64'(tgt_of(1)),      64'd2);
        check_eq("w2_t1080_busy",   64'(wave_busy),      64'd1);
        ticks(478);
        check_eq("w2_t1558_active", 64'(missile_active), 64'b0010);
        check_eq("w2_t1558_done",   64'(done_cnt),       64'd0);
        ticks(1);
        check_eq("w2_t1559_active", 64'(missile_active), 64'b0000);
        check_eq("w2_t1559_impact", 64'(impact),         64'b0010);
        check_eq("w2_t1559_done",   64'(wave_done),      64'd0);
        step(1'b0, 1'b0, 4'b0000);
        check_eq("w2_done_pulse",  64'(wave_done),     64'd1);
        check_eq("w2_idle_busy",   64'(wave_busy),     64'd0);
        check_eq("w2_idle_state",  64'(dut.state_q),   64'(IDLE));
        step(1'b0, 1'b0, 4'b0000);
        check_eq("w2_done_clear",  64'(wave_done),     64'd0);
        check_eq("w2_done_count",  64'(done_cnt),      64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_missile_dispatcher.md
ENEMY_MISSILE_DISPATCHER -- requirements
Module: enemy_missile_dispatcher

Interface
REQ-001 Parameter N_SLOTS, default 4: number of concurrent enemy missile slots.
REQ-002 Parameter Y_MAX, default 479: impact row (9-bit).
REQ-003 Parameter STEP, default 1: rows advanced per frame tick.
REQ-004 Parameter SPAWN_INTERVAL, default 60: frame ticks between launch attempts.
REQ-005 Parameter WAVE_SIZE, default 10: missiles per wave.
REQ-006 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 target_sel  in  3  current target index from the targeting shift register.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame.
REQ-010 wave_start  in  1  one-cycle pulse starting a wave.
REQ-011 kill  in  N_SLOTS  per-slot destroy request (collision).
REQ-012 missile_active  out  N_SLOTS  slot occupied.
REQ-013 missile_y  out  9*N_SLOTS  packed per-slot row, slot i at bits [9i+8:9i].
REQ-014 missile_tgt  out  2*N_SLOTS  packed per-slot target index.
REQ-015 impact  out  N_SLOTS  one-cycle pulse per slot reaching Y_MAX.
REQ-016 wave_busy  out  1  FSM not IDLE.
REQ-017 wave_done  out  1  one-cycle pulse on wave completion.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, DRAIN.
REQ-019 IDLE -> LAUNCH on wave_start: budget := WAVE_SIZE, spawn counter := 0; wave_start in LAUNCH/DRAIN ignored.
REQ-020 In LAUNCH, spawn counter SHALL increment on frame_tick, saturating at SPAWN_INTERVAL-1.
REQ-021 Launch condition: LAUNCH, frame_tick, counter == SPAWN_INTERVAL-1, budget > 0, and at least one slot free at start of cycle.
REQ-022 On launch: lowest-index free slot active, y := 0, tgt := target_sel saturated to 2 (values 3..7 -> 2), budget decremented, counter := 0.
REQ-023 No free slot at terminal count: counter holds; launch retried on each subsequent frame_tick.
REQ-024 LAUNCH -> DRAIN when budget reaches 0.
REQ-025 DRAIN -> IDLE when no slot active; wave_done pulses on that transition cycle.
REQ-026 On frame_tick each active slot (launched before this cycle) SHALL add STEP to y; newly launched slot not advanced that tick.
REQ-027 If y + STEP >= Y_MAX: slot cleared, y := 0, impact[i] pulses the following cycle, missile_tgt[i] holds its value during that pulse.
REQ-028 Multiple slots may impact on the same tick; all corresponding impact bits pulse together.
REQ-029 kill[i] on active slot: slot cleared that edge, no impact; kill beats impact and movement in the same cycle; kill on free slot ignored.
REQ-030 A slot freed in cycle n SHALL NOT be reallocated before cycle n+1.
REQ-031 y arithmetic in 10 bits internally; no wrap past Y_MAX.

Reset
REQ-032 rst_n low asynchronously: FSM IDLE, budget 0, counter 0, all outputs 0 (missile_active, missile_y, missile_tgt, impact, wave_busy, wave_done).
REQ-033 Reset mid-wave SHALL discard all in-flight missiles without impact pulses; release synchronous to clk.

Structure
REQ-034 Shared package SHALL hold FSM state enum, default Y_MAX/STEP/SPAWN_INTERVAL/WAVE_SIZE, and target-index width (2).
REQ-035 One sub-module, enemy_missile_slot, SHALL implement a single slot (active, y, tgt, kill/move/impact), instantiated N_SLOTS times; the allocator/FSM stays in the parent.

Verification
REQ-036 Reset, wave_start, 60 frame_ticks, target_sel=1 -> slot0 active, y=0, tgt=1, budget 9.
REQ-037 Slot at y=478, STEP=1, frame_tick -> slot freed, impact=4'b0001 next cycle, tgt still visible.
REQ-038 All 4 slots active at terminal count -> no launch, counter holds; kill[2] -> next terminal tick launches into slot 2.
REQ-039 kill[0] and impact condition on slot0 same cycle -> slot cleared, impact[0] stays 0.
REQ-040 target_sel=5 at launch -> tgt=2.
REQ-041 Full wave of 10 with no kills -> DRAIN after 10th launch, wave_done single pulse when last slot impacts; rst_n low mid-wave -> all outputs 0 immediately, no impact.
